// File: rtl/pipe_pkg.sv
// Shared pipeline-register types for the RV32I core: E-stage control bundle and encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_XOR = 3'b100
  } alu_ctrl_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_t   alu_ctrl;
    logic        alu_src;
  } ctrl_e_t;

  localparam ctrl_e_t NOP_CTRL = '0;
  localparam int      CTRL_W   = $bits(ctrl_e_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline flop bank: sync active-low reset, then clear (bubble), then enable (load).
module pipe_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// Decode->Execute pipeline register with stall/flush; optional bubble counter under `ID_EX_PERF_EN.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic [2:0]        ALUcontrolD,
  input  logic              ALUSrcD,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  PCD,
  input  logic [WIDTH-1:0]  PCPlus4D,
  input  logic [WIDTH-1:0]  ImmExtD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic [2:0]        ALUcontrolE,
  output logic              ALUSrcE,
  output logic [WIDTH-1:0]  RD1E,
  output logic [WIDTH-1:0]  RD2E,
  output logic [WIDTH-1:0]  PCE,
  output logic [WIDTH-1:0]  PCPlus4E,
  output logic [WIDTH-1:0]  ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [31:0]       BubbleCntE
);

  localparam int DATA_W = 5*WIDTH + 3*REG_AW;

  ctrl_e_t            ctrl_d, ctrl_q;
  logic [CTRL_W-1:0]  ctrl_vec_q;
  logic [DATA_W-1:0]  data_d, data_q;

  // A non-valid slot keeps its operands but must never cause writes or redirects.
  always_comb begin
    ctrl_d            = NOP_CTRL;
    ctrl_d.valid      = ValidD;
    ctrl_d.reg_write  = RegWriteD & ValidD;
    ctrl_d.result_src = result_src_t'(ResultSrcD);
    ctrl_d.mem_write  = MemWriteD & ValidD;
    ctrl_d.jump       = JumpD & ValidD;
    ctrl_d.branch     = BranchD & ValidD;
    ctrl_d.alu_ctrl   = alu_ctrl_t'(ALUcontrolD);
    ctrl_d.alu_src    = ALUSrcD;
  end

  assign data_d = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};

  pipe_reg #(.WIDTH(CTRL_W)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (~StallE),
    .clr_i (FlushE),
    .d_i   (ctrl_d),
    .q_o   (ctrl_vec_q)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (~StallE),
    .clr_i (FlushE),
    .d_i   (data_d),
    .q_o   (data_q)
  );

  assign ctrl_q      = ctrl_e_t'(ctrl_vec_q);
  assign ValidE      = ctrl_q.valid;
  assign RegWriteE   = ctrl_q.reg_write;
  assign ResultSrcE  = ctrl_q.result_src;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUcontrolE = ctrl_q.alu_ctrl;
  assign ALUSrcE     = ctrl_q.alu_src;

  assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE} = data_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating count of inserted bubbles; stall has no effect on it.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign BubbleCntE = bubble_cnt_q;
`else
  assign BubbleCntE = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios then randomized traffic vs a reference model.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n, StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUcontrolD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUcontrolE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, BubbleCntE;
  logic [4:0]  Rs1E, Rs2E, RdE;

  typedef struct {
    logic        valid, regw, memw, jump, branch, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t        m;
  logic [31:0] m_bc;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] saved;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUcontrolD(ALUcontrolD), .ALUSrcD(ALUSrcD), .RD1D(RD1D), .RD2D(RD2D),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUcontrolE(ALUcontrolE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BubbleCntE(BubbleCntE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ValidE", 32'(ValidE), 32'(m.valid));
    check("RegWriteE", 32'(RegWriteE), 32'(m.regw));
    check("ResultSrcE", 32'(ResultSrcE), 32'(m.rsrc));
    check("MemWriteE", 32'(MemWriteE), 32'(m.memw));
    check("JumpE", 32'(JumpE), 32'(m.jump));
    check("BranchE", 32'(BranchE), 32'(m.branch));
    check("ALUcontrolE", 32'(ALUcontrolE), 32'(m.aluc));
    check("ALUSrcE", 32'(ALUSrcE), 32'(m.alusrc));
    check("RD1E", RD1E, m.rd1);
    check("RD2E", RD2E, m.rd2);
    check("PCE", PCE, m.pc);
    check("PCPlus4E", PCPlus4E, m.pc4);
    check("ImmExtE", ImmExtE, m.imm);
    check("Rs1E", 32'(Rs1E), 32'(m.rs1));
    check("Rs2E", 32'(Rs2E), 32'(m.rs2));
    check("RdE", 32'(RdE), 32'(m.rd));
`ifdef ID_EX_PERF_EN
    check("BubbleCntE", BubbleCntE, m_bc);
`else
    check("BubbleCntE", BubbleCntE, 32'd0);
`endif
  endtask

  task automatic clear_model();
    m = '{valid:0, regw:0, memw:0, jump:0, branch:0, alusrc:0, rsrc:0, aluc:0,
          rd1:0, rd2:0, pc:0, pc4:0, imm:0, rs1:0, rs2:0, rd:0};
  endtask

  // Reference behaviour of one rising edge, using the inputs currently driven.
  task automatic model_edge();
    if (!rst_n) begin
      clear_model();
      m_bc = 32'd0;
    end else if (FlushE) begin
      clear_model();
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
    end else if (!StallE) begin
      m.valid  = ValidD;
      m.regw   = ValidD ? RegWriteD : 1'b0;
      m.memw   = ValidD ? MemWriteD : 1'b0;
      m.jump   = ValidD ? JumpD : 1'b0;
      m.branch = ValidD ? BranchD : 1'b0;
      m.alusrc = ALUSrcD;
      m.rsrc   = ResultSrcD;
      m.aluc   = ALUcontrolD;
      m.rd1 = RD1D; m.rd2 = RD2D; m.pc = PCD; m.pc4 = PCPlus4D; m.imm = ImmExtD;
      m.rs1 = Rs1D; m.rs2 = Rs2D; m.rd = RdD;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_d();
    ValidD = 1'($urandom); RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
    JumpD = 1'($urandom); BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
    ResultSrcD = 2'($urandom_range(0, 2)); ALUcontrolD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = PCD + 32'd4; ImmExtD = $urandom;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
  endtask

  task automatic all_ones();
    ValidD = 1; RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; ALUSrcD = 1;
    ResultSrcD = 2'b11; ALUcontrolD = 3'b111;
    RD1D = '1; RD2D = '1; PCD = '1; PCPlus4D = '1; ImmExtD = '1;
    Rs1D = '1; Rs2D = '1; RdD = '1;
  endtask

  initial begin
    clear_model();
    m_bc = 32'd0;
    StallE = 0; FlushE = 0;
    rst_n = 0; all_ones();
    @(negedge clk);

    // 1: reset with all-ones inputs, then release and load
    step();
    check("rst_ValidE", 32'(ValidE), 32'd0);
    check("rst_RD1E", RD1E, 32'd0);
    rst_n = 1;
    step();
    check("load_ones_RdE", 32'(RdE), 32'h1F);

    // 2: plain load of a sub
    rand_d();
    RD1D = 32'h5; RD2D = 32'h3; ALUcontrolD = 3'b001; RdD = 5'd7; ValidD = 1;
    step();
    check("t2_RD1E", RD1E, 32'h5);
    check("t2_RD2E", RD2E, 32'h3);
    check("t2_ALUc", 32'(ALUcontrolE), 32'd1);
    check("t2_RdE", 32'(RdE), 32'd7);
    check("t2_ValidE", 32'(ValidE), 32'd1);

    // 3: three stalled cycles with changing inputs, then release
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step();
      check("t3_hold_RD1E", RD1E, 32'h5);
    end
    StallE = 0;
    rand_d();
    saved = RD1D;
    step();
    check("t3_release_RD1E", RD1E, saved);

    // 4: flush beats a simultaneous stall
    rand_d();
    RegWriteD = 1; MemWriteD = 1; ValidD = 1;
    FlushE = 1; StallE = 1;
    step();
    check("t4_RegWriteE", 32'(RegWriteE), 32'd0);
    check("t4_MemWriteE", 32'(MemWriteE), 32'd0);
    check("t4_ALUc", 32'(ALUcontrolE), 32'd0);
    check("t4_ValidE", 32'(ValidE), 32'd0);
    FlushE = 0; StallE = 0;

    // 5: invalid slot squashes side effects only
    rand_d();
    ValidD = 0; RegWriteD = 1; BranchD = 1; RD1D = 32'hDEAD_BEEF;
    step();
    check("t5_RegWriteE", 32'(RegWriteE), 32'd0);
    check("t5_BranchE", 32'(BranchE), 32'd0);
    check("t5_RD1E", RD1E, 32'hDEAD_BEEF);

    // Reset during a stall+flush: reset wins, next edge loads normally
    StallE = 1; FlushE = 1; rst_n = 0; rand_d();
    step();
    StallE = 0; FlushE = 0; rst_n = 1; rand_d(); ValidD = 1;
    step();
    check("rst_then_load_ValidE", 32'(ValidE), 32'd1);

`ifdef ID_EX_PERF_EN
    // 6: bubble counting and saturation
    rst_n = 0; step(); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      rand_d(); FlushE = 1; StallE = (i == 2);
      step();
    end
    FlushE = 0; StallE = 1; step(); StallE = 0;
    check("t6_cnt4", BubbleCntE, 32'd4);
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    m_bc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      rand_d(); FlushE = 1;
      step();
    end
    FlushE = 0;
    check("t6_sat", BubbleCntE, 32'hFFFF_FFFF);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_d();
      ValidD = ($urandom_range(0, 9) < 8);
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 6) == 0);
      rst_n  = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
